// File: rtl/ipm2t_hssthp_lpll_resp_v1_0.sv
// LPLL far-end responder: turns LPLL_POWERDOWN/LPLL_RST into a deterministic LPLL_READY.
// Optional lock-loss injection is enabled by IPM2T_HSSTHP_LPLL_RESP_FAULT_EN.
module ipm2t_hssthp_lpll_resp_v1_0 #(
   parameter int unsigned PWRUP_CYCLES = 16,
   parameter int unsigned CAL_CYCLES   = 64,
   parameter int unsigned LOCK_CYCLES  = 128,
   parameter int unsigned CHATTER_EN   = 0,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       LPLL_POWERDOWN,
   input  logic       LPLL_RST,
   output logic       LPLL_READY,
   output logic [2:0] o_state,
   output logic [7:0] o_lock_cnt,
   input  logic       i_fault_req,
   input  logic [7:0] i_fault_len
);

   typedef enum logic [2:0] {
      ST_PD     = 3'd0,
      ST_PWRUP  = 3'd1,
      ST_HOLD   = 3'd2,
      ST_CAL    = 3'd3,
      ST_LOCK   = 3'd4,
      ST_LOCKED = 3'd5,
      ST_FAULT  = 3'd6
   } state_t;

   localparam logic [CNT_WIDTH-1:0] PWRUP_LOAD = CNT_WIDTH'(PWRUP_CYCLES - 32'd1);
   localparam logic [CNT_WIDTH-1:0] CAL_LOAD   = CNT_WIDTH'(CAL_CYCLES - 32'd1);
   localparam logic [CNT_WIDTH-1:0] LOCK_LOAD  = CNT_WIDTH'(LOCK_CYCLES - 32'd1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           lock_cnt_q, lock_cnt_d;
   logic                 ready_q, ready_d;
   logic                 pd_m, pd_s, rst_m, rst_s;
   logic                 expired;
   logic                 fault_go;
   logic [CNT_WIDTH-1:0] fault_load;

   // Two-flop synchronizers; reset to the "held in powerdown/reset" level
   always_ff @(posedge clk) begin
      if (rst) begin
         pd_m  <= 1'b1;
         pd_s  <= 1'b1;
         rst_m <= 1'b1;
         rst_s <= 1'b1;
      end else begin
         pd_m  <= LPLL_POWERDOWN;
         pd_s  <= pd_m;
         rst_m <= LPLL_RST;
         rst_s <= rst_m;
      end
   end

`ifdef IPM2T_HSSTHP_LPLL_RESP_FAULT_EN
   // Fault duration of 0 behaves as 1 cycle
   assign fault_go   = i_fault_req;
   assign fault_load = (i_fault_len == 8'd0) ? '0 : CNT_WIDTH'(i_fault_len - 8'd1);
`else
   logic unused_fault;
   assign fault_go     = 1'b0;
   assign fault_load   = '0;
   assign unused_fault = ^{i_fault_req, i_fault_len};
`endif

   assign expired = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_PD;
         cnt_q      <= '0;
         lock_cnt_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_cnt_q <= lock_cnt_d;
         ready_q    <= ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = expired ? '0 : cnt_q - CNT_WIDTH'(1);
      lock_cnt_d = lock_cnt_q;
      ready_d    = 1'b0;

      case (state_q)
         ST_PD: begin
            if (!pd_s) begin
               state_d = ST_PWRUP;
               cnt_d   = PWRUP_LOAD;
            end
         end
         ST_PWRUP: begin
            if (expired) begin
               if (rst_s) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_CAL;
                  cnt_d   = CAL_LOAD;
               end
            end
         end
         ST_HOLD: begin
            if (!rst_s) begin
               state_d = ST_CAL;
               cnt_d   = CAL_LOAD;
            end
         end
         ST_CAL: begin
            if (expired) begin
               state_d = ST_LOCK;
               cnt_d   = LOCK_LOAD;
            end
         end
         ST_LOCK: begin
            if (expired) state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (fault_go) begin
               state_d = ST_FAULT;
               cnt_d   = fault_load;
            end
         end
         ST_FAULT: begin
            if (expired) begin
               state_d = ST_LOCK;
               cnt_d   = LOCK_LOAD;
            end
         end
         default: state_d = ST_PD;
      endcase

      // Overrides beat both expiry and fault; the running count is dropped
      if (pd_s) begin
         state_d = ST_PD;
         cnt_d   = '0;
      end else if (rst_s && (state_q != ST_PD) && (state_q != ST_PWRUP)) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
      end

      if ((state_q == ST_LOCK) && (state_d == ST_LOCKED) && (lock_cnt_q != 8'hFF))
         lock_cnt_d = lock_cnt_q + 8'd1;

      ready_d = (state_d == ST_LOCKED) ||
                ((CHATTER_EN != 0) && (state_d == ST_LOCK) && (cnt_d[1:0] == 2'b00));
   end

   assign LPLL_READY = ready_q;
   assign o_state    = state_q;
   assign o_lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_ipm2t_hssthp_lpll_resp_v1_0.sv
// Bench for the LPLL responder: a default instance plus a short-timing chatter instance, sharing inputs.
module tb_ipm2t_hssthp_lpll_resp_v1_0;

`ifdef IPM2T_HSSTHP_LPLL_RESP_FAULT_EN
   localparam bit FEN = 1'b1;
`else
   localparam bit FEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, pd, rs, freq;
   logic [7:0] flen;
   logic       rdy0, rdy1;
   logic [2:0] st0, st1;
   logic [7:0] lc0, lc1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ipm2t_hssthp_lpll_resp_v1_0 dut (
      .clk(clk), .rst(rst), .LPLL_POWERDOWN(pd), .LPLL_RST(rs), .LPLL_READY(rdy0),
      .o_state(st0), .o_lock_cnt(lc0), .i_fault_req(freq), .i_fault_len(flen)
   );

   ipm2t_hssthp_lpll_resp_v1_0 #(
      .PWRUP_CYCLES(4), .CAL_CYCLES(8), .LOCK_CYCLES(16), .CHATTER_EN(1), .CNT_WIDTH(16)
   ) dut_ch (
      .clk(clk), .rst(rst), .LPLL_POWERDOWN(pd), .LPLL_RST(rs), .LPLL_READY(rdy1),
      .o_state(st1), .o_lock_cnt(lc1), .i_fault_req(freq), .i_fault_len(flen)
   );

   // Reference model: phase plus cycles-elapsed-in-phase, fed through a 2-deep input delay line
   int m_ph[2], m_el[2], m_dur[2], m_lock[2], m_rdy[2];
   int pw_of[2], ca_of[2], lk_of[2], ch_of[2];
   bit d_pd0, d_pd1, d_rs0, d_rs1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit spd, srs, done, stay;
      int nph, ndur;
      if (rst) begin
         d_pd0 = 1'b1; d_pd1 = 1'b1; d_rs0 = 1'b1; d_rs1 = 1'b1;
         for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_el[i] = 0; m_dur[i] = 0; m_lock[i] = 0; m_rdy[i] = 0;
         end
         return;
      end
      spd = d_pd1; srs = d_rs1;
      d_pd1 = d_pd0; d_pd0 = pd;
      d_rs1 = d_rs0; d_rs0 = rs;
      for (int i = 0; i < 2; i++) begin
         done = (m_el[i] + 1 >= m_dur[i]);
         stay = 1'b1;
         nph  = m_ph[i];
         ndur = 0;
         if (spd) begin
            nph = 0; stay = (m_ph[i] == 0);
         end else if (srs && m_ph[i] >= 2) begin
            nph = 2; stay = (m_ph[i] == 2);
         end else begin
            case (m_ph[i])
               0: begin nph = 1; ndur = pw_of[i]; stay = 1'b0; end
               1: if (done) begin nph = srs ? 2 : 3; ndur = ca_of[i]; stay = 1'b0; end
               2: begin nph = 3; ndur = ca_of[i]; stay = 1'b0; end
               3: if (done) begin nph = 4; ndur = lk_of[i]; stay = 1'b0; end
               4: if (done) begin
                     nph = 5; stay = 1'b0;
                     if (m_lock[i] < 255) m_lock[i]++;
                  end
               5: if (FEN && freq) begin
                     nph = 6; ndur = (flen == 8'd0) ? 1 : int'(flen); stay = 1'b0;
                  end
               6: if (done) begin nph = 4; ndur = lk_of[i]; stay = 1'b0; end
               default: ;
            endcase
         end
         if (stay) m_el[i]++;
         else begin m_ph[i] = nph; m_el[i] = 0; m_dur[i] = ndur; end
         m_rdy[i] = (m_ph[i] == 5 ||
                     (ch_of[i] != 0 && m_ph[i] == 4 && ((m_dur[i] - 1 - m_el[i]) % 4) == 0)) ? 1 : 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_ready0", int'(rdy0), m_rdy[0]);
      chk("model_state0", int'(st0),  m_ph[0]);
      chk("model_lock0",  int'(lc0),  m_lock[0]);
      chk("model_ready1", int'(rdy1), m_rdy[1]);
      chk("model_state1", int'(st1),  m_ph[1]);
      chk("model_lock1",  int'(lc1),  m_lock[1]);
   endtask

   typedef struct {
      bit         pd;
      bit         rs;
      bit         fr;
      logic [7:0] fl;
      int         w;
      int         er;
      int         es;
      int         el;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit p, input bit r, input bit f, input int l, input int w,
                      input int er, input int es, input int el);
      vec_t v;
      v.pd = p; v.rs = r; v.fr = f; v.fl = 8'(l); v.w = w; v.er = er; v.es = es; v.el = el;
      tbl.push_back(v);
   endtask

   initial begin
      int rst_len;
      int fr1, fs6, fl4, fl5;
      bit seen;
      int chat;

      pw_of[0] = 16; ca_of[0] = 64; lk_of[0] = 128; ch_of[0] = 0;
      pw_of[1] = 4;  ca_of[1] = 8;  lk_of[1] = 16;  ch_of[1] = 1;

      fr1 = FEN ? 0 : 1;
      fs6 = FEN ? 6 : 5;
      fl4 = FEN ? 4 : 3;
      fl5 = FEN ? 5 : 3;

      // pd rs fr len wait | ready state lock  (default instance)
      add(1, 1, 0, 0,   6,  0, 0, 0);
      add(0, 0, 0, 0, 210,  0, 4, 0);
      add(0, 0, 0, 0,   1,  1, 5, 1);
      add(0, 1, 0, 0,   1,  1, 5, 1);
      add(0, 0, 0, 0,   1,  1, 5, 1);
      add(0, 0, 0, 0,   1,  0, 2, 1);
      add(0, 0, 0, 0,   1,  0, 3, 1);
      add(0, 0, 0, 0, 191,  0, 4, 1);
      add(0, 0, 0, 0,   1,  1, 5, 2);
      add(1, 0, 0, 0,   2,  1, 5, 2);
      add(1, 0, 0, 0,   1,  0, 0, 2);
      add(0, 1, 0, 0,  40,  0, 2, 2);
      add(0, 0, 0, 0,   2,  0, 2, 2);
      add(0, 0, 0, 0,   1,  0, 3, 2);
      add(0, 0, 0, 0, 191,  0, 4, 2);
      add(0, 0, 0, 0,   1,  1, 5, 3);
      add(0, 0, 1, 5,   1,  fr1, fs6, 3);
      add(0, 0, 0, 5, 132,  fr1, FEN ? 4 : 5, 3);
      add(0, 0, 0, 5,   1,  1, 5, fl4);
      add(0, 0, 1, 0,   1,  fr1, fs6, fl4);
      add(0, 0, 0, 0,   1,  fr1, FEN ? 4 : 5, fl4);
      add(0, 0, 0, 0, 127,  fr1, FEN ? 4 : 5, fl4);
      add(0, 0, 0, 0,   1,  1, 5, fl5);
      add(1, 0, 0, 0,   3,  0, 0, fl5);
      add(0, 0, 0, 0,  19,  0, 3, fl5);

      rst = 1'b1; pd = 1'b1; rs = 1'b1; freq = 1'b0; flen = 8'd0;
      repeat (4) tick();
      rst = 1'b0;
      chk("reset_ready0", int'(rdy0), 0);
      chk("reset_state0", int'(st0), 0);
      chk("reset_lock0",  int'(lc0), 0);
      chk("reset_ready1", int'(rdy1), 0);

      foreach (tbl[i]) begin
         pd = tbl[i].pd; rs = tbl[i].rs; freq = tbl[i].fr; flen = tbl[i].fl;
         repeat (tbl[i].w) tick();
         chk($sformatf("vec%0d_ready", i), int'(rdy0), tbl[i].er);
         chk($sformatf("vec%0d_state", i), int'(st0),  tbl[i].es);
         chk($sformatf("vec%0d_lock", i),  int'(lc0),  tbl[i].el);
      end

      // Reset while calibrating, then a full relock from reset
      rst = 1'b1; tick(); rst = 1'b0;
      chk("cal_rst_state", int'(st0), 0);
      chk("cal_rst_lock",  int'(lc0), 0);
      chk("cal_rst_ready", int'(rdy0), 0);
      chk("cal_rst_lock1", int'(lc1), 0);
      repeat (210) tick();
      chk("relock_pre_ready", int'(rdy0), 0);
      tick();
      chk("relock_ready", int'(rdy0), 1);
      chk("relock_state", int'(st0), 5);
      chk("relock_lock",  int'(lc0), 1);

      // Random traffic against the model
      rst_len = 0;
      for (int c = 0; c < 4000; c++) begin
         pd = ($urandom_range(0, 1499) == 0);
         if (rst_len > 0) rst_len--;
         else if ($urandom_range(0, 699) == 0) rst_len = $urandom_range(1, 50);
         rs   = (rst_len > 0);
         freq = ($urandom_range(0, 19) == 0);
         flen = 8'($urandom_range(0, 7));
         rst  = ($urandom_range(0, 2999) == 0);
         tick();
      end

      // Repeated relocks on the chatter instance: pulse count and counter saturation
      rst = 1'b0; pd = 1'b0; rs = 1'b0; freq = 1'b0; flen = 8'd0;
      repeat (5) tick();
      for (int it = 0; it < 300; it++) begin
         chat = 0;
         seen = 1'b0;
         rs = 1'b1; tick(); rs = 1'b0;
         repeat (4) tick();
         for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (st1 == 3'd4 && rdy1) chat++;
            if (st1 == 3'd5) seen = 1'b1;
         end
         if (it == 1) chk("chatter_pulses", chat, 4);
         if (!seen) chk("relock_timeout", int'(seen), 1);
      end
      chk("sat_lock", int'(lc1), 255);
      chk("sat_state", int'(st1), 5);
      chk("sat_ready", int'(rdy1), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
